// File: rtl/mem_stage_if.sv
// Memory-side bus of the MEM stage: request/write-enable/address/data
// from the stage, read data and acknowledge back from memory.
interface mem_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through to MEM/WB, runs loads and
// stores over a req/ack memory bus while stalling upstream, and parks in a
// terminal HALTED state after a halt instruction retires.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that go
// unacknowledged for TIMEOUT_CYCLES BUSY cycles (MemErr pulses on abort).
module mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   // EX/MEM pipeline register
   input  logic        RegWriteIn,
   input  logic        MemtoRegIn,
   input  logic        MemWriteIn,
   input  logic [31:0] ALUResultIn,
   input  logic [4:0]  WriteRegIn,
   input  logic [31:0] WriteDataIn,
   input  logic        HaltIn,
   // memory bus
   mem_stage_if.master mem,
   // MEM/WB pipeline register
   output logic        RegWriteOut,
   output logic        MemtoRegOut,
   output logic [31:0] ReadDataOut,
   output logic [31:0] ALUResultOut,
   output logic [4:0]  WriteRegOut,
   output logic        HaltOut,
   output logic        Stall,
   output logic        MemErr
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HALTED} state_t;

   state_t      r_state, w_next;
   logic        w_mem_op;
   logic        w_stall, w_req, w_done, w_timeout;
   logic [31:0] r_addr, r_wdata;
   logic        r_is_store, r_regwrite, r_halt;
   logic [4:0]  r_wreg;

   assign w_mem_op = MemtoRegIn | MemWriteIn;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;

   assign w_timeout = (r_state == S_BUSY) && !mem.mem_ack &&
                      (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Count consecutive unacknowledged BUSY cycles; clear on abort or exit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_cnt <= '0;
      else if (r_state == S_BUSY && !mem.mem_ack && !w_timeout)
         r_cnt <= r_cnt + 1'b1;
      else
         r_cnt <= '0;
   end

   // One-cycle error pulse on the abort edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         MemErr <= 1'b0;
      else
         MemErr <= w_timeout;
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
   assign MemErr           = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state, stall and bus request decode
   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      w_req   = 1'b0;
      w_done  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_stall = w_mem_op;
            if (w_mem_op)
               w_next = S_BUSY;
            else if (HaltIn)
               w_next = S_HALTED;
         end
         S_BUSY: begin
            w_req = 1'b1;
            if (mem.mem_ack) begin
               w_done = 1'b1;
               w_next = r_halt ? S_HALTED : S_IDLE;
            end else if (w_timeout) begin
               w_next = S_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         S_HALTED: w_stall = 1'b1;
         default:  w_next  = S_IDLE;
      endcase
   end

   // Stall is forced low while reset is held, even if a memory op is presented
   assign Stall         = reset & w_stall;
   assign mem.mem_req   = w_req;
   assign mem.mem_we    = w_req & r_is_store;
   assign mem.mem_addr  = r_addr;
   assign mem.mem_wdata = r_wdata;

   // Capture the memory instruction when it is accepted in IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_is_store <= 1'b0;
         r_regwrite <= 1'b0;
         r_halt     <= 1'b0;
         r_wreg     <= '0;
      end else if (r_state == S_IDLE && w_mem_op) begin
         r_addr     <= ALUResultIn;
         r_wdata    <= WriteDataIn;
         r_is_store <= MemWriteIn;
         r_regwrite <= RegWriteIn;
         r_halt     <= HaltIn;
         r_wreg     <= WriteRegIn;
      end
   end

   // MEM/WB register: pass-through, completion write, bubble or halt hold
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RegWriteOut  <= 1'b0;
         MemtoRegOut  <= 1'b0;
         ReadDataOut  <= '0;
         ALUResultOut <= '0;
         WriteRegOut  <= '0;
         HaltOut      <= 1'b0;
      end else if (r_state == S_HALTED) begin
         RegWriteOut <= 1'b0;
         MemtoRegOut <= 1'b0;
         HaltOut     <= 1'b1;
      end else if (w_done) begin
         RegWriteOut  <= r_regwrite;
         MemtoRegOut  <= ~r_is_store;
         ReadDataOut  <= r_is_store ? 32'h0 : mem.mem_rdata;
         ALUResultOut <= r_addr;
         WriteRegOut  <= r_wreg;
         HaltOut      <= r_halt;
      end else if (r_state == S_IDLE && !w_mem_op) begin
         RegWriteOut  <= RegWriteIn;
         MemtoRegOut  <= 1'b0;
         ReadDataOut  <= '0;
         ALUResultOut <= ALUResultIn;
         WriteRegOut  <= WriteRegIn;
         HaltOut      <= HaltIn;
      end else begin
         RegWriteOut <= 1'b0;
         MemtoRegOut <= 1'b0;
         HaltOut     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load with wait states,
// zero-wait store, halt behind a load, reset mid-access, and (with
// MEM_TIMEOUT_EN) the unacknowledged-access abort.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        RegWriteIn = 1'b0, MemtoRegIn = 1'b0, MemWriteIn = 1'b0, HaltIn = 1'b0;
   logic [31:0] ALUResultIn = '0, WriteDataIn = '0;
   logic [4:0]  WriteRegIn = '0;
   logic        RegWriteOut, MemtoRegOut, HaltOut, Stall, MemErr;
   logic [31:0] ReadDataOut, ALUResultOut;
   logic [4:0]  WriteRegOut;

   int n_assert = 0;
   int n_fail   = 0;

   mem_stage_if mem ();

   mem_stage #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .RegWriteIn(RegWriteIn), .MemtoRegIn(MemtoRegIn), .MemWriteIn(MemWriteIn),
      .ALUResultIn(ALUResultIn), .WriteRegIn(WriteRegIn), .WriteDataIn(WriteDataIn),
      .HaltIn(HaltIn), .mem(mem.master),
      .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut), .ReadDataOut(ReadDataOut),
      .ALUResultOut(ALUResultOut), .WriteRegOut(WriteRegOut), .HaltOut(HaltOut),
      .Stall(Stall), .MemErr(MemErr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic rw, input logic m2r, input logic mw, input logic h,
                         input logic [31:0] alu, input logic [4:0] wr, input logic [31:0] wd);
      RegWriteIn = rw; MemtoRegIn = m2r; MemWriteIn = mw; HaltIn = h;
      ALUResultIn = alu; WriteRegIn = wr; WriteDataIn = wd;
   endtask

   initial begin
      mem.mem_ack   = 1'b0;
      mem.mem_rdata = '0;

      // Reset with a load presented: no stall, no request, everything zero
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h55, 5'd3, 32'h0);
      tick(); tick();
      chk("rst_stall", Stall, 0);
      chk("rst_req", mem.mem_req, 0);
      chk("rst_regwrite", RegWriteOut, 0);
      chk("rst_memtoreg", MemtoRegOut, 0);
      chk("rst_rdata", ReadDataOut, 0);
      chk("rst_alu", ALUResultOut, 0);
      chk("rst_wreg", WriteRegOut, 0);
      chk("rst_halt", HaltOut, 0);
      chk("rst_memerr", MemErr, 0);

      // ALU pass-through
      reset = 1'b1;
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000002A, 5'd5, 32'h0);
      #1 chk("alu_stall_pre", Stall, 0);
      tick();
      chk("alu_regwrite", RegWriteOut, 1);
      chk("alu_result", ALUResultOut, 32'h2A);
      chk("alu_wreg", WriteRegOut, 5);
      chk("alu_rdata", ReadDataOut, 0);
      chk("alu_stall_post", Stall, 0);

      // Load, ack three cycles after the request
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 5'd7, 32'h0);
      mem.mem_rdata = 32'hDEADBEEF;
      #1 chk("ld_stall0", Stall, 1);
      chk("ld_req0", mem.mem_req, 0);
      tick();
      chk("ld_bubble1", RegWriteOut, 0);
      chk("ld_alu_held", ALUResultOut, 32'h2A);
      chk("ld_req1", mem.mem_req, 1);
      chk("ld_we", mem.mem_we, 0);
      chk("ld_addr1", mem.mem_addr, 32'h100);
      chk("ld_stall1", Stall, 1);
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF0000, 5'd0, 32'h0);
      tick();
      chk("ld_stall2", Stall, 1);
      chk("ld_addr2", mem.mem_addr, 32'h100);
      chk("ld_bubble2", MemtoRegOut, 0);
      tick();
      chk("ld_stall3", Stall, 1);
      mem.mem_ack = 1'b1;
      #1 chk("ld_stall_ack", Stall, 0);
      tick();
      chk("ld_rdata", ReadDataOut, 32'hDEADBEEF);
      chk("ld_memtoreg", MemtoRegOut, 1);
      chk("ld_regwrite", RegWriteOut, 1);
      chk("ld_alu", ALUResultOut, 32'h100);
      chk("ld_wreg", WriteRegOut, 7);
      chk("ld_req_done", mem.mem_req, 0);
      mem.mem_ack = 1'b0;

      // Store (with MemtoRegIn also set) acknowledged immediately
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 5'd3, 32'h12345678);
      mem.mem_ack   = 1'b1;
      mem.mem_rdata = 32'hCAFEF00D;
      #1 chk("st_stall0", Stall, 1);
      chk("st_req0", mem.mem_req, 0);
      tick();
      chk("st_req1", mem.mem_req, 1);
      chk("st_we", mem.mem_we, 1);
      chk("st_wdata", mem.mem_wdata, 32'h12345678);
      chk("st_addr", mem.mem_addr, 32'h200);
      chk("st_stall1", Stall, 0);
      chk("st_rdata_held", ReadDataOut, 32'hDEADBEEF);
      tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
      mem.mem_ack = 1'b0;
      chk("st_regwrite", RegWriteOut, 0);
      chk("st_memtoreg", MemtoRegOut, 0);
      chk("st_rdata", ReadDataOut, 0);
      chk("st_alu", ALUResultOut, 32'h200);
      #1 chk("st_idle_req", mem.mem_req, 0);
      chk("st_idle_stall", Stall, 0);

      // Halt riding on a load: HaltOut only at completion, then frozen
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 5'd9, 32'h0);
      mem.mem_rdata = 32'h0BADF00D;
      #1 chk("h_stall0", Stall, 1);
      tick();
      chk("h_halt1", HaltOut, 0);
      chk("h_req1", mem.mem_req, 1);
      tick();
      chk("h_halt2", HaltOut, 0);
      chk("h_stall2", Stall, 1);
      mem.mem_ack = 1'b1;
      tick();
      chk("h_halt_done", HaltOut, 1);
      chk("h_regwrite_done", RegWriteOut, 1);
      chk("h_rdata", ReadDataOut, 32'h0BADF00D);
      chk("h_wreg", WriteRegOut, 9);
      chk("h_req_done", mem.mem_req, 0);
      chk("h_stall_done", Stall, 1);
      mem.mem_ack = 1'b0;
      set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h444, 5'd1, 32'h9);
      tick(); tick();
      chk("h_halt_hold", HaltOut, 1);
      chk("h_regwrite_hold", RegWriteOut, 0);
      chk("h_alu_hold", ALUResultOut, 32'h300);
      chk("h_req_hold", mem.mem_req, 0);
      chk("h_stall_hold", Stall, 1);

      // Reset out of HALTED, then reset in the middle of a load
      reset = 1'b0;
      #1 chk("r_halt_clr", HaltOut, 0);
      chk("r_stall_clr", Stall, 0);
      tick();
      reset = 1'b1;
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 5'd4, 32'h0);
      tick(); tick();
      chk("r_busy_req", mem.mem_req, 1);
      #3 reset = 1'b0;
      #1 chk("r_async_req", mem.mem_req, 0);
      chk("r_async_stall", Stall, 0);
      chk("r_async_regwrite", RegWriteOut, 0);
      chk("r_async_alu", ALUResultOut, 0);
      chk("r_async_rdata", ReadDataOut, 0);
      tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
      mem.mem_ack   = 1'b1;
      mem.mem_rdata = 32'h11111111;
      reset = 1'b1;
      tick();
      chk("r_late_rdata", ReadDataOut, 0);
      chk("r_late_regwrite", RegWriteOut, 0);
      chk("r_late_alu", ALUResultOut, 0);
      chk("r_late_req", mem.mem_req, 0);
      mem.mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
      // Load never acknowledged: abort on the 16th BUSY cycle
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 5'd6, 32'h0);
      tick();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
      repeat (14) tick();
      chk("to_stall15", Stall, 1);
      chk("to_err15", MemErr, 0);
      tick();
      chk("to_stall16", Stall, 0);
      chk("to_req16", mem.mem_req, 1);
      tick();
      chk("to_err", MemErr, 1);
      chk("to_req_idle", mem.mem_req, 0);
      chk("to_regwrite", RegWriteOut, 0);
      chk("to_stall_idle", Stall, 0);
      tick();
      chk("to_err_pulse", MemErr, 0);
`else
      // Load never acknowledged: waits indefinitely, no error
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 5'd6, 32'h0);
      tick();
      repeat (20) tick();
      chk("nto_stall", Stall, 1);
      chk("nto_req", mem.mem_req, 1);
      chk("nto_err", MemErr, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the BUSY cycles allowed before abort when MEM_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have input ports RegWriteIn 1, MemtoRegIn 1 (load), MemWriteIn 1 (store), ALUResultIn 32 (address/result), WriteRegIn 5, WriteDataIn 32 (store data), HaltIn 1; these are the EX/MEM pipeline-register outputs.
REQ-005 SHALL have memory-side ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32, mem_ack in 1.
REQ-006 SHALL have MEM/WB-side outputs RegWriteOut 1, MemtoRegOut 1, ReadDataOut 32, ALUResultOut 32, WriteRegOut 5, HaltOut 1 (all registered).
REQ-007 SHALL have outputs Stall 1 (combinational, freezes upstream stages) and MemErr 1 (registered, one-cycle pulse).

Function
REQ-008 SHALL implement FSM states IDLE, BUSY, HALTED.
REQ-009 A memory op SHALL be MemtoRegIn=1 or MemWriteIn=1; if both are 1, the op SHALL be a store and MemtoRegOut SHALL be written 0.
REQ-010 In IDLE with no memory op and HaltIn=0, all MEM/WB outputs SHALL load their In values at the next edge (latency 1), with ReadDataOut=0.
REQ-011 In IDLE with a memory op, Stall SHALL be 1 that cycle; at the edge the FSM SHALL latch ALUResultIn, WriteDataIn, and the op type, and SHALL go to BUSY.
REQ-012 In BUSY, mem_req SHALL be 1, mem_we SHALL be 1 for a store and 0 for a load, and mem_addr/mem_wdata SHALL hold the latched values stably.
REQ-013 In BUSY, Stall SHALL equal NOT mem_ack.
REQ-014 At the edge where mem_ack=1 in BUSY, MEM/WB outputs SHALL load the held instruction, ReadDataOut SHALL load mem_rdata for a load (0 for a store), and the FSM SHALL return to IDLE; minimum memory-op latency is 2 cycles.
REQ-015 On every edge where Stall=1 and no completion occurs, a bubble SHALL be written: RegWriteOut=0, MemtoRegOut=0, HaltOut=0; other outputs are held.
REQ-016 mem_ack SHALL be ignored outside BUSY.
REQ-017 mem_req SHALL be 0 in IDLE and HALTED.
REQ-018 In IDLE with HaltIn=1 and no memory op, HaltOut SHALL be 1 at the next edge and the FSM SHALL enter HALTED.
REQ-019 HaltIn=1 together with a memory op SHALL complete the memory op first, then assert HaltOut with the completion write and enter HALTED.
REQ-020 HALTED SHALL be terminal until reset: it ignores inputs, keeps HaltOut=1, keeps RegWriteOut=0, and keeps Stall=1.

Reset
REQ-021 While reset=0, regardless of clk, the state SHALL be IDLE and all registered outputs SHALL be 0 (including MemErr and HaltOut).
REQ-022 While reset=0, mem_req SHALL be 0 immediately, and Stall SHALL be 0.
REQ-023 A reset asserted during BUSY SHALL abandon the access with no MEM/WB write; any late mem_ack SHALL be ignored.
REQ-024 After reset deasserts, the first edge SHALL be processed normally from IDLE.

Configuration
REQ-025 With macro MEM_TIMEOUT_EN defined, a counter SHALL count BUSY cycles with mem_ack=0.
REQ-026 With MEM_TIMEOUT_EN defined, on the TIMEOUT_CYCLES-th such cycle the access SHALL be aborted: Stall=0 that cycle, a bubble is written, MemErr=1 for one cycle, the FSM returns to IDLE, and the counter clears.
REQ-027 With MEM_TIMEOUT_EN undefined, BUSY SHALL wait indefinitely, MemErr SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-028 Bench SHALL cover ALU pass-through: RegWriteIn=1, ALUResultIn=0x0000002A, WriteRegIn=5 -> next cycle RegWriteOut=1, ALUResultOut=0x2A, WriteRegOut=5, Stall never 1.
REQ-029 Bench SHALL cover a load with mem_ack three cycles after mem_req: ALUResultIn=0x100, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0; Stall=1 for 4 cycles; then ReadDataOut=0xDEADBEEF, MemtoRegOut=1; bubbles before completion.
REQ-030 Bench SHALL cover a store with zero-wait ack: MemWriteIn=1, ALUResultIn=0x200, WriteDataIn=0x12345678 -> mem_we=1, mem_wdata=0x12345678, Stall=1 for 1 cycle, RegWriteOut=0.
REQ-031 Bench SHALL cover halt: HaltIn=1 with a load in flight -> HaltOut=1 only at load completion; subsequent inputs ignored; mem_req stays 0.
REQ-032 Bench SHALL cover reset during BUSY: drop reset mid-wait -> mem_req=0 asynchronously, outputs 0; an ack after release does not change outputs.
REQ-033 Bench SHALL cover timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16): a load that is never acked -> MemErr pulses once after 16 BUSY cycles, Stall drops, and the FSM is back in IDLE.
